// File: rtl/alu_issue.sv
// Operand-issue and writeback stage around the combinational alu execute unit.
// Define ALU_ISSUE_FWD_EN for operand forwarding; otherwise RAW hazards interlock.
module alu_issue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [4:0]       in_rs1_idx,
  input  logic [4:0]       in_rs2_idx,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_use_imm,
  input  logic [4:0]       in_rd,
  input  logic             flush,
  input  logic             out_ready,
  input  logic [XLEN-1:0]  alu_result,
  output logic [XLEN-1:0]  a,
  output logic [XLEN-1:0]  b,
  output logic [3:0]       Alu_ctrl,
  output logic             ex_valid,
  output logic [4:0]       ex_rd,
  output logic             wb_we,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             ex_valid_q, ex_valid_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             wb_we_q, wb_we_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             retire, accept, interlock;
  logic [XLEN-1:0]  rs1_val, rs2_val;

  assign retire = ex_valid_q && out_ready && !flush;

`ifdef ALU_ISSUE_FWD_EN
  // Newest value wins: the retiring EX result, then the pending WB write, then the regfile.
  always_comb begin
    rs1_val = in_rs1_data;
    if (in_rs1_idx != 5'd0) begin
      if (retire && ex_rd_q == in_rs1_idx) begin
        rs1_val = alu_result;
      end else if (wb_we_q && wb_rd_q == in_rs1_idx) begin
        rs1_val = wb_data_q;
      end
    end
  end

  always_comb begin
    rs2_val = in_rs2_data;
    if (in_rs2_idx != 5'd0) begin
      if (retire && ex_rd_q == in_rs2_idx) begin
        rs2_val = alu_result;
      end else if (wb_we_q && wb_rd_q == in_rs2_idx) begin
        rs2_val = wb_data_q;
      end
    end
  end

  assign interlock = 1'b0;
`else
  logic ex_hit1, ex_hit2, wb_hit1, wb_hit2;

  assign rs1_val = in_rs1_data;
  assign rs2_val = in_rs2_data;

  // wb_we already implies wb_rd != 0, so only the EX side needs the x0 guard.
  always_comb begin
    ex_hit1   = ex_valid_q && (ex_rd_q != 5'd0) && (ex_rd_q == in_rs1_idx);
    ex_hit2   = ex_valid_q && (ex_rd_q != 5'd0) && (ex_rd_q == in_rs2_idx) && !in_use_imm;
    wb_hit1   = wb_we_q && (wb_rd_q == in_rs1_idx);
    wb_hit2   = wb_we_q && (wb_rd_q == in_rs2_idx) && !in_use_imm;
    interlock = ex_hit1 || ex_hit2 || wb_hit1 || wb_hit2;
  end
`endif

  assign in_ready = !flush && (!ex_valid_q || out_ready) && !interlock;
  assign accept   = in_valid && in_ready;

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    ex_rd_d    = ex_rd_q;
    ex_valid_d = ex_valid_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      a_d        = rs1_val;
      b_d        = in_use_imm ? in_imm : rs2_val;
      ctrl_d     = in_op;
      ex_rd_d    = in_rd;
      ex_valid_d = 1'b1;
    end else if (retire) begin
      ex_valid_d = 1'b0;
    end
  end

  always_comb begin
    wb_we_d   = retire && (ex_rd_q != 5'd0);
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (retire) begin
      wb_rd_d   = ex_rd_q;
      wb_data_d = alu_result;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= 4'b0000;
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= 5'd0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign Alu_ctrl  = ctrl_q;
  assign ex_valid  = ex_valid_q;
  assign ex_rd     = ex_rd_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: transaction-level model of the EX/WB slots and the register file,
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_alu_issue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 6;
  localparam int          CMAX  = 63;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_use_imm, flush, out_ready;
  logic [3:0]       in_op, Alu_ctrl;
  logic [4:0]       in_rs1_idx, in_rs2_idx, in_rd, ex_rd, wb_rd;
  logic [XLEN-1:0]  in_rs1_data, in_rs2_data, in_imm, alu_result, a, b, wb_data;
  logic             ex_valid, wb_we;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] x, input logic [31:0] y,
                                         input logic [3:0] c);
    case (c)
      4'b0000: return x + y;
      4'b0001: return x - y;
      4'b0010: return x & y;
      4'b0101: return x << y[4:0];
      4'b1001: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(a, b, Alu_ctrl);

  alu_issue #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd),
    .flush(flush), .out_ready(out_ready), .alu_result(alu_result),
    .a(a), .b(b), .Alu_ctrl(Alu_ctrl), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall_cnt(stall_cnt)
  );

  // Model: register file plus one in-flight EX transaction and one pending WB write.
  logic [31:0] rf_m [32];
  logic        m_ex_v, m_wb_we;
  logic [4:0]  m_ex_rd, m_wb_rd;
  logic [3:0]  m_ex_op;
  logic [31:0] m_ex_a, m_ex_b, m_ex_res, m_wb_data;
  int          m_stall;
  logic [36:0] wr_log [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] newest(input logic [4:0] x);
    if (x == 5'd0) return 32'd0;
    if (m_ex_v && m_ex_rd == x) return m_ex_res;
    if (m_wb_we && m_wb_rd == x) return m_wb_data;
    return rf_m[x];
  endfunction

  function automatic logic pending(input logic [4:0] x);
    return (x != 5'd0) && ((m_ex_v && m_ex_rd == x) || (m_wb_we && m_wb_rd == x));
  endfunction

  task automatic cycle(input logic v, input logic [3:0] op, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd, input logic ui,
                       input logic [31:0] imm, input logic fl, input logic ordy,
                       output logic acc);
    logic [31:0] v1, v2;
    logic        il, rdy, ret;
    @(negedge clk);
    in_valid = v; in_op = op; in_rs1_idx = r1; in_rs2_idx = r2; in_rd = rd;
    in_use_imm = ui; in_imm = imm; flush = fl; out_ready = ordy;
    in_rs1_data = rf_m[r1]; in_rs2_data = rf_m[r2];
    #1;
    v1 = newest(r1);
    v2 = newest(r2);
    il = 1'b0;
`ifndef ALU_ISSUE_FWD_EN
    il = pending(r1) || (!ui && pending(r2));
`endif
    rdy = !fl && (!m_ex_v || ordy) && !il;
    acc = v && rdy;
    ret = m_ex_v && ordy && !fl;
    chk("in_ready", in_ready, rdy);
    chk("ex_valid", ex_valid, m_ex_v);
    if (m_ex_v) begin
      chk("a", a, m_ex_a);
      chk("b", b, m_ex_b);
      chk("alu_ctrl", Alu_ctrl, m_ex_op);
      chk("ex_rd", ex_rd, m_ex_rd);
    end
    chk("wb_we", wb_we, m_wb_we);
    if (m_wb_we) begin
      chk("wb_rd", wb_rd, m_wb_rd);
      chk("wb_data", wb_data, m_wb_data);
    end
    chk("stall_cnt", stall_cnt, m_stall);
    if (wb_we) wr_log.push_back({wb_rd, wb_data});
    @(posedge clk);
    #1;
    if (m_wb_we) rf_m[m_wb_rd] = m_wb_data;
    m_wb_we = ret && (m_ex_rd != 5'd0);
    if (ret) begin
      m_wb_rd   = m_ex_rd;
      m_wb_data = m_ex_res;
    end
    if (v && !rdy && m_stall < CMAX) m_stall++;
    if (fl) begin
      m_ex_v = 1'b0;
    end else if (acc) begin
      m_ex_v   = 1'b1;
      m_ex_a   = v1;
      m_ex_b   = ui ? imm : v2;
      m_ex_op  = op;
      m_ex_rd  = rd;
      m_ex_res = alu_fn(m_ex_a, m_ex_b, op);
    end else if (ret) begin
      m_ex_v = 1'b0;
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic ui, input logic [31:0] imm);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 12) begin
      cycle(1'b1, op, r1, r2, rd, ui, imm, 1'b0, 1'b1, acc);
      n++;
    end
    if (!acc) chk("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b1, acc);
  endtask

  // Reset arrives mid-cycle and must clear state without waiting for a clock edge.
  task automatic hit_reset();
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_ctrl", Alu_ctrl, 0);
    chk("rst_ex_rd", ex_rd, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_stall", stall_cnt, 0);
    @(negedge clk);
    rst     = 1'b0;
    m_ex_v  = 1'b0;
    m_wb_we = 1'b0;
    m_stall = 0;
  endtask

  initial begin
    logic       acc;
    logic [3:0] ops [6];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0101, 4'b1001, 4'b0111};
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    m_ex_v = 1'b0; m_wb_we = 1'b0; m_stall = 0;
    m_ex_rd = 5'd0; m_wb_rd = 5'd0; m_ex_op = 4'd0;
    m_ex_a = 0; m_ex_b = 0; m_ex_res = 0; m_wb_data = 0;
    rst = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_rs1_idx = 5'd0; in_rs2_idx = 5'd0;
    in_rd = 5'd0; in_use_imm = 1'b0; in_imm = 0; flush = 1'b0; out_ready = 1'b1;
    in_rs1_data = 0; in_rs2_data = 0;
    hit_reset();

    // Forward from EX (or interlock for two cycles without forwarding).
    rf_m[5] = 32'd10; rf_m[6] = 32'd20; rf_m[7] = 32'd60;
    wr_log.delete();
    issue(4'b0000, 5'd5, 5'd6, 5'd1, 1'b0, 32'd0);
    issue(4'b0001, 5'd1, 5'd0, 5'd2, 1'b1, 32'd15);
    chk("t1_a", a, 30);
    chk("t1_result", alu_result, 15);
`ifdef ALU_ISSUE_FWD_EN
    chk("t1_stall", stall_cnt, 0);
`else
    chk("t1_stall", stall_cnt, 2);
`endif
    idle(4);
    chk("t1_nwr", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("t1_wr0", wr_log[0], {5'd1, 32'd30});
      chk("t1_wr1", wr_log[1], {5'd2, 32'd15});
    end

    // Forward from WB after one idle cycle.
    rf_m[3] = 32'd0;
    issue(4'b0000, 5'd7, 5'd0, 5'd3, 1'b1, 32'd40);
    idle(1);
    issue(4'b0000, 5'd3, 5'd0, 5'd4, 1'b1, 32'd0);
    chk("t2_a", a, 100);
    idle(4);

    // x0 destination never writes and is never forwarded.
    wr_log.delete();
    issue(4'b0000, 5'd0, 5'd0, 5'd0, 1'b1, 32'd5);
    issue(4'b0000, 5'd0, 5'd0, 5'd4, 1'b1, 32'd1);
    chk("t3_a", a, 0);
    idle(4);
    chk("t3_nwr", wr_log.size(), 1);
    if (wr_log.size() == 1) chk("t3_wr0", wr_log[0], {5'd4, 32'd1});

    // Backpressure: three blocked cycles, EX operands held.
    hit_reset();
    issue(4'b0000, 5'd5, 5'd0, 5'd5, 1'b1, 32'd7);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0000, 5'd6, 5'd0, 5'd6, 1'b1, 32'd1, 1'b0, 1'b0, acc);
    chk("t4_stall", stall_cnt, 3);
    chk("t4_ex_valid", ex_valid, 1);
    chk("t4_a", a, 10);
    chk("t4_b", b, 7);
    chk("t4_ctrl", Alu_ctrl, 0);
    idle(4);

    // Flush kills EX, blocks accept, lets the pending write finish.
    wr_log.delete();
    cycle(1'b1, 4'b0000, 5'd7, 5'd0, 5'd8, 1'b1, 32'd1, 1'b0, 1'b1, acc);
    cycle(1'b1, 4'b0000, 5'd6, 5'd0, 5'd9, 1'b1, 32'd2, 1'b0, 1'b1, acc);
    cycle(1'b1, 4'b0000, 5'd6, 5'd0, 5'd10, 1'b1, 32'd3, 1'b1, 1'b1, acc);
    chk("t5_ex_valid", ex_valid, 0);
    chk("t5_wb_we", wb_we, 0);
    idle(3);
    chk("t5_nwr", wr_log.size(), 1);
    if (wr_log.size() == 1) chk("t5_wr0", wr_log[0], {5'd8, 32'd61});

    // Randomized traffic with frequent hazards, flushes, stalls and occasional resets.
    for (int i = 1; i < 32; i++) rf_m[i] = $urandom;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) hit_reset();
      cycle($urandom_range(0, 3) != 0, ops[$urandom_range(0, 5)],
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0,
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : 32'($urandom),
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, acc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-issue and writeback stage wrapped around the `alu` execute unit. It accepts decoded ALU operations from decode over a valid/ready handshake and registers `a`, `b` and `Alu_ctrl` straight into the `alu` inputs. It captures the `alu` `Result` on retire and drives the register-file write port. It resolves read-after-write hazards by forwarding, or by interlock when forwarding is compiled out.

## Interface
- `XLEN`, 32, datapath width; must equal the `alu` width.
- `CNT_W`, 16, width of the stall counter.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  decode offers an operation.
- `in_ready`  out  1  stage accepts the operation this cycle.
- `in_op`  in  4  ALU control code: 0000 ADD, 0001 SUB, 0010 AND, 0101 SLL, 1001 SLT; other codes pass through untouched.
- `in_rs1_idx`, `in_rs2_idx`  in  5  source register indices.
- `in_rs1_data`, `in_rs2_data`  in  XLEN  register-file read data.
- `in_imm`  in  XLEN  immediate.
- `in_use_imm`  in  1  `b` takes `in_imm` instead of rs2.
- `in_rd`  in  5  destination register; 0 means no write.
- `flush`  in  1  kill the in-flight operation.
- `out_ready`  in  1  downstream accepts the executing operation.
- `alu_result`  in  XLEN  `Result` fed back from `alu`.
- `a`, `b`  out  XLEN  registered `alu` operands.
- `Alu_ctrl`  out  4  registered `alu` control.
- `ex_valid`  out  1  `a`/`b`/`Alu_ctrl` hold a live operation.
- `ex_rd`  out  5  destination of the live operation.
- `wb_we`  out  1  register-file write enable.
- `wb_rd`  out  5  write index.
- `wb_data`  out  XLEN  write data.
- `stall_cnt`  out  CNT_W  saturating count of stalled cycles.

## Operation
- **Accept:** `in_ready = !flush && (!ex_valid || out_ready) && !interlock`. A transfer happens when `in_valid && in_ready`.
- **On accept:** `a` takes fwd(rs1). `b` takes `in_imm` if `in_use_imm`, else fwd(rs2). `Alu_ctrl` takes `in_op`, `ex_rd` takes `in_rd`, and `ex_valid` is set to 1.
- **Retire:** the operation retires when `ex_valid && out_ready && !flush`. On retire, `wb_we` is set to (`ex_rd != 0`), `wb_rd` takes `ex_rd`, and `wb_data` takes `alu_result`.
- **No retire:** if the operation does not retire, `wb_we` is 0 next cycle. `ex_valid` clears on retire without a new accept.
- **Forwarding (fwd(x), priority order):**
  1. Retiring EX operation with `ex_rd == x`, `x != 0`: use `alu_result`.
  2. Otherwise `wb_we && wb_rd == x`: use `wb_data`.
  3. Otherwise: use the register-file data.
- **Register-file timing:** a write issued with `wb_we` is visible on read data from the following cycle.
- **Register x0:** never forwarded; it always reads the register-file value.
- **Flush:** the following cycle has `ex_valid = 0`. The EX operation does not retire and nothing is accepted. `wb_*` completes normally.
- **Backpressure:** while `ex_valid && !out_ready`, `a`, `b`, `Alu_ctrl` and `ex_rd` hold stable.
- **Stall counter:** `stall_cnt` increments on every cycle with `in_valid && !in_ready`. It saturates at all-ones.

## Timing
- Reset values, applied immediately on `rst` even mid-operation:
  - `a`, `b`, `wb_data` = 0.
  - `Alu_ctrl` = 0000.
  - `ex_valid`, `wb_we` = 0.
  - `ex_rd`, `wb_rd` = 0.
  - `stall_cnt` = 0.
- `in_ready` is combinational and is 1 in the first cycle after reset.
- Accept to `alu` inputs: 1 cycle. `alu` is combinational, so `Result` is valid in the same cycle as `ex_valid`.
- Retire to `wb_we`: 1 cycle. Accept to register-file visibility: 3 cycles minimum.
- Back-to-back dependent operations issue every cycle when forwarding is enabled.
- Simultaneous accept and retire in one cycle is legal: the new operation replaces the old one, and the old one moves to `wb_*`.

## Configuration
- `ALU_ISSUE_FWD_EN`, defined: forwarding as described; `interlock` is 0.
- `ALU_ISSUE_FWD_EN`, undefined:
  - No forwarding: operands always take the register-file data.
  - `interlock` = (`ex_valid && ex_rd != 0 && ex_rd` matches a used source) OR (`wb_we && wb_rd` matches a used source).
  - rs2 counts as a used source only when `!in_use_imm`.
  - Interlocked cycles count toward `stall_cnt`.

## Test plan
1. **Forward from EX:** ADD rd=1, a=10, b=20, then SUB rd=2, rs1=1, b=15 on the next cycle. Required: second issue has `a`=30 and `alu_result`=15; two consecutive writes (1,30) then (2,15).
2. **Forward from WB:** ADD rd=3 gives 100, one idle cycle, then an operation reading rs1=3 with `in_rs1_data`=0. Required: `a`=100 (from `wb_data`).
3. **x0 not forwarded:** operation with rd=0 and result 5 (produces no write), then an operation reading rs1=0 with data 0. Required: `a`=0 and `wb_we` never 1.
4. **Backpressure:** `out_ready`=0 for 3 cycles with `ex_valid`=1 and `in_valid`=1. Required: `in_ready`=0, `a`/`b`/`Alu_ctrl` stable, `stall_cnt`=3.
5. **Flush:** `flush` asserted with `ex_valid`=1, `in_valid`=1 and `wb_we`=1. Required next cycle: `ex_valid`=0, no accept, and the pending write completes.
6. **Interlock (macro undefined):** dependent back-to-back ADD→SUB. Required: `in_ready`=0 for 2 cycles, then accept with register-file data 30; `stall_cnt`=2.
